// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: operand/command request and result/flag response, each with valid/ready.
interface pipelined_alu_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] operandA, operandB, result;
  logic [2:0] command;
  logic carryout, zero, overflow;
  modport master (
    output in_valid, operandA, operandB, command, out_ready,
    input  in_ready, out_valid, result, carryout, zero, overflow
  );
  modport slave (
    input  in_valid, operandA, operandB, command, out_ready,
    output in_ready, out_valid, result, carryout, zero, overflow
  );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage valid/ready ALU (operand register, then compute+result register).
// Define ALU_STICKY_OVF_EN to add the ovf_clear/sticky_ovf sticky overflow flag.
module pipelined_alu #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic reset,
`ifdef ALU_STICKY_OVF_EN
  input  logic ovf_clear,
  output logic sticky_ovf,
`endif
  pipelined_alu_if.slave bus
);
  typedef enum logic [2:0] {
    C_ADD, C_SUB, C_XOR, C_SLT, C_AND, C_NAND, C_NOR, C_OR
  } cmd_t;
  logic s1_valid, s2_valid, s1_load, s2_load;
  logic is_sub, is_arith, ovf, lt;
  logic [WIDTH-1:0] a, b, bx, res;
  logic [WIDTH:0] sum;
  cmd_t cmd;
  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign bus.in_ready = !s1_valid || !s2_valid || bus.out_ready;
  assign bus.out_valid = s2_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        a <= bus.operandA;
        b <= bus.operandB;
        cmd <= cmd_t'(bus.command);
      end
    end
  end
  // SLT reuses the subtractor: signed less-than is sign XOR overflow of A-B
  always_comb begin
    is_sub = cmd == C_SUB || cmd == C_SLT;
    is_arith = cmd == C_ADD || cmd == C_SUB;
    bx = is_sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    lt = sum[WIDTH-1] ^ ovf;
  end
  always_comb begin
    res = sum[WIDTH-1:0];
    case (cmd)
      C_XOR:  res = a ^ b;
      C_SLT:  res = {{(WIDTH-1){1'b0}}, lt};
      C_AND:  res = a & b;
      C_NAND: res = ~(a & b);
      C_NOR:  res = ~(a | b);
      C_OR:   res = a | b;
      default: res = sum[WIDTH-1:0];
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      bus.result <= '0;
      bus.carryout <= 1'b0;
      bus.zero <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.result <= res;
        bus.carryout <= is_arith && sum[WIDTH];
        bus.zero <= res == '0;
        bus.overflow <= is_arith && ovf;
      end
    end
  end
`ifdef ALU_STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (reset)
      sticky_ovf <= 1'b0;
    else if (bus.out_valid && bus.out_ready && bus.overflow)
      sticky_ovf <= 1'b1;
    else if (ovf_clear)
      sticky_ovf <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: scoreboard bench; driver pushes model results, monitor pops on each out-transfer.
module tb_pipelined_alu;
  localparam int W = 32;
  localparam longint SMAX = (longint'(1) <<< (W-1)) - 1;
  localparam longint SMIN = -SMAX - 1;
  typedef struct packed {
    logic [W-1:0] r;
    logic co, zr, ov;
  } resp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pipelined_alu_if #(.WIDTH(W)) bus();
`ifdef ALU_STICKY_OVF_EN
  logic ovf_clear = 1'b0;
  logic sticky_ovf;
`endif
  pipelined_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
`ifdef ALU_STICKY_OVF_EN
    .ovf_clear(ovf_clear),
    .sticky_ovf(sticky_ovf),
`endif
    .bus(bus)
  );
  resp_t q[$];
  int checks = 0, passes = 0, delivered = 0, cyc = 0;
  bit rand_bp = 0;
  always @(posedge clk) cyc++;
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  function automatic resp_t model(logic [2:0] c, logic [W-1:0] a, logic [W-1:0] b);
    resp_t e;
    longint sa, sb, s;
    logic [W:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    case (c)
      3'd0: begin
        u = {1'b0, a} + {1'b0, b};
        e.r = u[W-1:0];
        e.co = u[W];
        s = sa + sb;
        e.ov = s > SMAX || s < SMIN;
      end
      3'd1: begin
        e.r = a - b;
        e.co = a >= b;
        s = sa - sb;
        e.ov = s > SMAX || s < SMIN;
      end
      3'd2: e.r = a ^ b;
      3'd3: e.r = (sa < sb) ? W'(1) : W'(0);
      3'd4: e.r = a & b;
      3'd5: e.r = ~(a & b);
      3'd6: e.r = ~(a | b);
      default: e.r = a | b;
    endcase
    e.zr = e.r == '0;
    return e;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.command = c;
    bus.operandA = a;
    bus.operandB = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready && !reset) begin
        q.push_back(model(c, a, b));
        done = 1;
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    check("drain_left", 64'(q.size()), 0);
  endtask
  always @(negedge clk) begin
    resp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got %0h expected none", bus.result);
      end else begin
        e = q.pop_front();
        delivered++;
        check("result", 64'(bus.result), 64'(e.r));
        check("carryout", 64'(bus.carryout), 64'(e.co));
        check("zero", 64'(bus.zero), 64'(e.zr));
        check("overflow", 64'(bus.overflow), 64'(e.ov));
      end
    end
  end
  always @(posedge clk) if (rand_bp) begin
    #1;
    bus.out_ready = $urandom_range(3) != 0;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish expected done");
    $fatal(1);
  end
  logic [2:0] dc[13] = '{0, 0, 1, 3, 3, 1, 0, 1, 2, 3, 4, 5, 6};
  logic [W-1:0] da[13] = '{32'h70000000, 32'hF0000000, 32'h0, 32'h90000000, 32'h10000000, 32'h5,
                           32'hA5, 32'hA5, 32'hA5, 32'hA5, 32'hA5, 32'hA5, 32'hA5};
  logic [W-1:0] db[13] = '{32'h70000000, 32'h10000000, 32'h1, 32'h10000000, 32'h90000000, 32'h5,
                           32'h3C, 32'h3C, 32'h3C, 32'h3C, 32'h3C, 32'h3C, 32'h3C};
  initial begin
    int c0, d0;
    logic [W-1:0] held;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.command = '0;
    bus.operandA = '0;
    bus.operandB = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_result", 64'(bus.result), 0);
    check("rst_flags", 64'({bus.carryout, bus.zero, bus.overflow}), 0);
    check("rst_in_ready", 64'(bus.in_ready), 1);
    step();
    send(3'd0, 32'h1, 32'h1);
    @(negedge clk);
    check("lat_one_edge_valid", 64'(bus.out_valid), 0);
    @(negedge clk);
    check("lat_two_edge_valid", 64'(bus.out_valid), 1);
    check("lat_result", 64'(bus.result), 64'h2);
    step();
    c0 = cyc;
    for (int i = 0; i < 13; i++) send(dc[i], da[i], db[i]);
    send(3'd7, 32'hA5, 32'h3C);
    check("throughput_cycles", 64'(cyc - c0), 14);
    drain();
    bus.out_ready = 1'b0;
    d0 = delivered;
    send(3'd0, 32'h1, 32'h2);
    send(3'd0, 32'h3, 32'h4);
    bus.in_valid = 1'b1;
    bus.operandA = 32'h5;
    bus.operandB = 32'h6;
    @(negedge clk);
    check("bp_in_ready", 64'(bus.in_ready), 0);
    check("bp_head_result", 64'(bus.result), 64'h3);
    held = bus.result;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("bp_hold_result", 64'(bus.result), 64'(held));
      check("bp_hold_valid", 64'(bus.out_valid), 1);
      check("bp_hold_in_ready", 64'(bus.in_ready), 0);
    end
    step();
    bus.out_ready = 1'b1;
    send(3'd0, 32'h5, 32'h6);
    send(3'd0, 32'h7, 32'h8);
    drain();
    check("bp_delivered", 64'(delivered - d0), 4);
    rand_bp = 1;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      a = $urandom_range(3) == 0 ? {$urandom_range(1) == 1, {(W-1){$urandom_range(1) == 1}}} : W'($urandom);
      b = $urandom_range(3) == 0 ? a : W'($urandom);
      if ($urandom_range(4) == 0) step();
      else send(3'($urandom_range(7)), a, b);
    end
    rand_bp = 0;
    step();
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;
    send(3'd0, 32'h11, 32'h22);
    send(3'd1, 32'h33, 32'h44);
    reset = 1'b1;
    q.delete();
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    d0 = delivered;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 0);
    check("midrst_in_ready", 64'(bus.in_ready), 1);
    repeat (5) step();
    check("midrst_no_stale", 64'(delivered - d0), 0);
    send(3'd1, 32'h0, 32'h1);
    drain();
    check("post_rst_delivered", 64'(delivered - d0), 1);
`ifdef ALU_STICKY_OVF_EN
    send(3'd0, 32'h7FFFFFFF, 32'h1);
    drain();
    step();
    check("sticky_set", 64'(sticky_ovf), 1);
    send(3'd0, 32'h1, 32'h1);
    drain();
    step();
    check("sticky_persist", 64'(sticky_ovf), 1);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    @(negedge clk);
    check("sticky_clear", 64'(sticky_ovf), 0);
    step();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
